// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 4-digit 7-segment driver with a shadowed BCD value,
// blanking between digit slots, leading-zero suppression and bad-digit flagging.
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic        load_i,
  input  logic        lz_en_i,
  output logic [3:0]  anode_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_o,
  output logic        err_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST      = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

  typedef enum logic [1:0] {D0, D1, D2, D3} digit_t;

  logic [CW-1:0] cnt;
  digit_t        digit;
  logic [15:0]   shadow_val;
  logic [3:0]    shadow_dp;
  logic [15:0]   pend_val;
  logic [3:0]    pend_dp;
  logic          pend_flag;

  logic          slot_end;
  logic          boundary;
  logic          blank;
  logic          suppress;
  logic [1:0]    idx;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic [3:1]    zero_from;
  logic          bad;
  logic [3:0]    nxt_anode;
  logic [6:0]    nxt_seg;
  logic          nxt_dp;

  always_comb begin
    slot_end = (cnt == LAST);
    boundary = slot_end && (digit == D3);
    blank    = (cnt < BLANK_LIM);
    idx      = digit;
    nib      = shadow_val[{idx, 2'b00} +: 4];

    // Digit k is a leading zero when it and every digit above it are zero.
    zero_from[3] = (shadow_val[15:12] == 4'd0);
    zero_from[2] = zero_from[3] && (shadow_val[11:8] == 4'd0);
    zero_from[1] = zero_from[2] && (shadow_val[7:4] == 4'd0);

    suppress = 1'b0;
    if (lz_en_i) begin
      case (digit)
        D1:      suppress = zero_from[1];
        D2:      suppress = zero_from[2];
        D3:      suppress = zero_from[3];
        default: suppress = 1'b0;
      endcase
    end

    case (nib)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b0111111;
    endcase

    bad = (shadow_val[3:0] > 4'd9) || (shadow_val[7:4] > 4'd9) ||
          (shadow_val[11:8] > 4'd9) || (shadow_val[15:12] > 4'd9);

    nxt_anode = blank ? 4'b1111 : ~(4'b0001 << idx);
    nxt_seg   = (blank || suppress) ? 7'b1111111 : glyph;
    nxt_dp    = (blank || suppress) ? 1'b1 : ~shadow_dp[idx];
  end

  // load_i is a one-cycle strobe with no back-pressure: a load away from the
  // frame boundary is parked in pending (last write wins) and promoted at the
  // boundary; a load on the boundary cycle goes straight to the shadow.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt        <= '0;
      digit      <= D0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_flag  <= 1'b0;
      anode_o    <= 4'b1111;
      seg_o      <= 7'b1111111;
      dp_o       <= 1'b1;
      frame_o    <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;

      if (slot_end) begin
        case (digit)
          D0:      digit <= D1;
          D1:      digit <= D2;
          D2:      digit <= D3;
          default: digit <= D0;
        endcase
      end

      if (load_i && boundary) begin
        shadow_val <= value_i;
        shadow_dp  <= dp_i;
        pend_flag  <= 1'b0;
      end else if (load_i) begin
        pend_val  <= value_i;
        pend_dp   <= dp_i;
        pend_flag <= 1'b1;
      end else if (boundary && pend_flag) begin
        shadow_val <= pend_val;
        shadow_dp  <= pend_dp;
        pend_flag  <= 1'b0;
      end

      anode_o <= nxt_anode;
      seg_o   <= nxt_seg;
      dp_o    <= nxt_dp;
      frame_o <= boundary;
      err_o   <= bad;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: per-frame expected digit records are
// queued by the stimulus and popped by a monitor at the start of each lit slot.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYCLES = 2;

  localparam logic [6:0] G0   = 7'b1000000;
  localparam logic [6:0] G1   = 7'b1111001;
  localparam logic [6:0] G2   = 7'b0100100;
  localparam logic [6:0] G3   = 7'b0110000;
  localparam logic [6:0] G4   = 7'b0011001;
  localparam logic [6:0] G5   = 7'b0010010;
  localparam logic [6:0] G7   = 7'b1111000;
  localparam logic [6:0] G8   = 7'b0000000;
  localparam logic [6:0] GD   = 7'b0111111;
  localparam logic [6:0] GOFF = 7'b1111111;

  logic        clk;
  logic        reset_i;
  logic [15:0] value_i;
  logic [3:0]  dp_i;
  logic        load_i;
  logic        lz_en_i;
  logic [3:0]  anode_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        frame_o;
  logic        err_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Each record is {anode, seg, dp} for one lit digit slot.
  logic [11:0] exp_q[$];
  logic [11:0] cur;
  logic        have_cur = 1'b0;
  logic [3:0]  prev_anode = 4'b1111;

  seg7_scan_driver #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .value_i(value_i),
    .dp_i   (dp_i),
    .load_i (load_i),
    .lz_en_i(lz_en_i),
    .anode_o(anode_o),
    .seg_o  (seg_o),
    .dp_o   (dp_o),
    .frame_o(frame_o),
    .err_o  (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                            input logic [6:0] s0, input logic [3:0] dpv);
    exp_q.push_back({4'b1110, s0, ~dpv[0]});
    exp_q.push_back({4'b1101, s1, ~dpv[1]});
    exp_q.push_back({4'b1011, s2, ~dpv[2]});
    exp_q.push_back({4'b0111, s3, ~dpv[3]});
  endtask

  // Runs ncyc cycles of one frame; cycle c ends at the c-th rising edge of the
  // frame. Loads at offsets la/lb (-1 for none) are sampled on that edge.
  task automatic run_frame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                           input logic [6:0] s0, input logic [3:0] dpv, input logic lz,
                           input logic err, input int ncyc,
                           input int la, input logic [15:0] va, input logic [3:0] da,
                           input int lb, input logic [15:0] vb, input logic [3:0] db);
    push_frame(s3, s2, s1, s0, dpv);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      lz_en_i = lz;
      if (c == la) begin
        load_i = 1'b1; value_i = va; dp_i = da;
      end else if (c == lb) begin
        load_i = 1'b1; value_i = vb; dp_i = db;
      end else begin
        load_i = 1'b0; value_i = 16'hdead; dp_i = 4'b1111;
      end
      @(posedge clk);
      #1;
      check("frame_o", frame_o, (c == 31));
      check("err_o", err_o, err);
      if ((c % 8) < 2) check("blank_phase", {anode_o, seg_o, dp_o}, 12'hfff);
    end
  endtask

  // Monitor: a blank-to-lit transition starts a new digit slot.
  always @(negedge clk) begin
    if (!reset_i && anode_o != 4'b1111) begin
      if (prev_anode == 4'b1111) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          have_cur = 1'b0;
          $display("FAIL exp_q_underflow: actual anode %b required no lit slot", anode_o);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
        end
      end
      if (have_cur) check("lit_slot", {anode_o, seg_o, dp_o}, cur);
    end
    prev_anode = anode_o;
  end

  initial begin
    reset_i = 1'b0;
    value_i = '0;
    dp_i    = '0;
    load_i  = 1'b0;
    lz_en_i = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    check("reset_out", {anode_o, seg_o, dp_o, frame_o, err_o}, {4'b1111, GOFF, 1'b1, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;

    // F0: cleared shadow; mid-frame load must not show until the boundary.
    run_frame(G0, G0, G0, G0, 4'b0000, 1'b0, 1'b0, 32, 12, 16'h1234, 4'b0010, -1, 16'h0, 4'h0);
    // F1: 1234 with dp on digit1.
    run_frame(G1, G2, G3, G4, 4'b0010, 1'b0, 1'b0, 32, 5, 16'h0070, 4'b0000, -1, 16'h0, 4'h0);
    // F2: 0070 with leading-zero suppression.
    run_frame(GOFF, GOFF, G7, G0, 4'b0000, 1'b1, 1'b0, 32, 20, 16'h0000, 4'b1111, -1, 16'h0, 4'h0);
    // F3: 0000 suppressed except digit0; suppressed dps stay dark. Two loads, last wins.
    run_frame(GOFF, GOFF, GOFF, G0, 4'b0001, 1'b1, 1'b0, 32, 3, 16'h1111, 4'b0000, 17, 16'h2222, 4'b0000);
    // F4: 2222; pending 9999 is discarded by the 5555 load on the boundary.
    run_frame(G2, G2, G2, G2, 4'b0000, 1'b0, 1'b0, 32, 10, 16'h9999, 4'b1111, 31, 16'h5555, 4'b0000);
    // F5, F6: 5555 holds; no stale pending promoted.
    run_frame(G5, G5, G5, G5, 4'b0000, 1'b0, 1'b0, 32, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    run_frame(G5, G5, G5, G5, 4'b0000, 1'b0, 1'b0, 32, 8, 16'h00A0, 4'b0000, -1, 16'h0, 4'h0);
    // F7: 00A0 shows a dash and raises err_o.
    run_frame(G0, G0, GD, G0, 4'b0000, 1'b0, 1'b1, 32, 4, 16'h0000, 4'b0000, -1, 16'h0, 4'h0);
    // F8: zeros, err_o cleared.
    run_frame(G0, G0, G0, G0, 4'b0000, 1'b0, 1'b0, 32, 2, 16'h8888, 4'b0101, -1, 16'h0, 4'h0);
    // F9: 8888 until reset lands during the D2 lit phase.
    run_frame(G8, G8, G8, G8, 4'b0101, 1'b0, 1'b0, 21, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    #3 reset_i = 1'b1;
    #1;
    check("reset_midscan", {anode_o, seg_o, dp_o, frame_o, err_o}, {4'b1111, GOFF, 1'b1, 1'b0, 1'b0});
    exp_q.delete();
    have_cur = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    // F10: scan restarts at D0 with a cleared shadow.
    run_frame(G0, G0, G0, G0, 4'b0000, 1'b0, 1'b0, 32, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    @(negedge clk);
    load_i = 1'b0;
    check("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
